// File: rtl/serial_link_pkg.sv
// Shared definitions for the serialised link (transmit-side select counter
// and receive-side demultiplexer).
//   LINK_WIDTH  : default bits per word
//   LINK_SEL_W  : select/index width for LINK_WIDTH
//   asm_state_e : receive assembly FSM state
package serial_link_pkg;

  localparam int unsigned LINK_WIDTH = 8;
  localparam int unsigned LINK_SEL_W = $clog2(LINK_WIDTH);

  typedef enum logic {
    IDLE     = 1'b0,
    ASSEMBLE = 1'b1
  } asm_state_e;

endpackage

// File: rtl/serial_demux_1to8_decoder.sv
// decoder_sel_onehot: binary select to one-hot write enable, the inverse of
// the transmit mux select. Purely combinational.
//   sel    in  SEL_W  slot index
//   en     in  1      qualifies the decode (all zeros when low)
//   onehot out WIDTH  one-hot enable, bit sel set when en
module decoder_sel_onehot #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = $clog2(WIDTH)
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [WIDTH-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (en && (sel == SEL_W'(i))) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_demux_1to8.sv
// serial_demux_1to8: receive-side 1:WIDTH serial demultiplexer. Each valid
// beat writes din into the assembly register slot addressed by the bit index;
// completed words are moved into a valid/ready holding register.
//   clk, rst_n  clock, asynchronous active-low reset
//   din         serial data bit
//   din_valid   din is a valid beat
//   sof         start of frame: realign index to 0, discard partial word
//   sel         index the next valid beat will be written to
//   dout        completed word (holding register)
//   dout_valid  dout holds an unconsumed word
//   dout_ready  consumer accepts dout when dout_valid & dout_ready
//   overrun     one-cycle pulse: completed word dropped, holding register full
module serial_demux_1to8
  import serial_link_pkg::*;
#(
  parameter int unsigned WIDTH     = LINK_WIDTH,
  parameter bit          MSB_FIRST = 1'b0,
  localparam int unsigned SEL_BITS = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                din,
  input  logic                din_valid,
  input  logic                sof,
  output logic [SEL_BITS-1:0] sel,
  output logic [WIDTH-1:0]    dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                overrun
);

  asm_state_e          state_q, state_d;
  logic [SEL_BITS-1:0] sel_q, sel_d;
  logic [WIDTH-1:0]    asm_q, asm_d;
  logic [WIDTH-1:0]    dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                overrun_q, overrun_d;

  logic [SEL_BITS-1:0] wr_sel;
  logic [SEL_BITS-1:0] slot_idx;
  logic [WIDTH-1:0]    we;
  logic [WIDTH-1:0]    asm_base;
  logic [WIDTH-1:0]    word;
  logic                complete;
  logic                accept;

  // A sof beat is written as if it were index 0 of a fresh word.
  assign wr_sel   = sof ? '0 : sel_q;
  assign slot_idx = MSB_FIRST ? (SEL_BITS'(WIDTH - 1) - wr_sel) : wr_sel;

  decoder_sel_onehot #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_BITS)
  ) u_decoder (
    .sel    (slot_idx),
    .en     (din_valid),
    .onehot (we)
  );

  // Start from a clean register on sof or when no partial word is held, so
  // earlier frames can never leak into the new word.
  assign asm_base = (sof || (state_q == IDLE)) ? '0 : asm_q;
  assign word     = (asm_base & ~we) | (we & {WIDTH{din}});
  assign complete = din_valid && !sof && (sel_q == SEL_BITS'(WIDTH - 1));
  assign accept   = complete && (!dout_valid_q || dout_ready);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    asm_d   = asm_q;
    if (sof && din_valid) begin
      sel_d   = SEL_BITS'(1);
      asm_d   = word;
      state_d = ASSEMBLE;
    end else if (sof) begin
      sel_d   = '0;
      asm_d   = '0;
      state_d = IDLE;
    end else if (din_valid) begin
      if (complete) begin
        sel_d   = '0;
        asm_d   = '0;
        state_d = IDLE;
      end else begin
        sel_d   = sel_q + SEL_BITS'(1);
        asm_d   = word;
        state_d = ASSEMBLE;
      end
    end
  end

  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = 1'b0;
    if (accept) begin
      dout_d       = word;
      dout_valid_d = 1'b1;
    end else if (complete) begin
      overrun_d    = 1'b1;
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      asm_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      asm_q        <= asm_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign sel        = sel_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_demux_1to8.sv
module tb_serial_demux_1to8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       sof = 1'b0;
  logic       dout_ready = 1'b1;

  logic [2:0] sel_l, sel_m;
  logic [7:0] dout_l, dout_m;
  logic       dv_l, dv_m;
  logic       ovr_l, ovr_m;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_demux_1to8 #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
    .sel(sel_l), .dout(dout_l), .dout_valid(dv_l), .dout_ready(dout_ready),
    .overrun(ovr_l)
  );

  serial_demux_1to8 #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
    .sel(sel_m), .dout(dout_m), .dout_valid(dv_m), .dout_ready(dout_ready),
    .overrun(ovr_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are applied at a negedge, sampled at the following posedge, and
  // the task returns at the next negedge where the result is visible.
  task automatic drive(input logic b, input logic v, input logic s);
    din = b; din_valid = v; sof = s;
    @(negedge clk);
    din = 1'b0; din_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] w, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) drive(w[i], 1'b1, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_sel", sel_l, 0);
    chk("rst_dout", dout_l, 0);
    chk("rst_dv", dv_l, 0);
    chk("rst_ovr", ovr_l, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: 4D, LSB first; MSB-first instance sees B2
    send_bits(8'h4D, 0, 6);
    chk("t1_sel7", sel_l, 7);
    chk("t1_dv_early", dv_l, 0);
    send_bits(8'h4D, 7, 7);
    chk("t1_dv", dv_l, 1);
    chk("t1_dout", dout_l, 8'h4D);
    chk("t1_dout_msb", dout_m, 8'hB2);
    chk("t1_sel_wrap", sel_l, 0);
    drive(1'b0, 1'b0, 1'b0);
    chk("t1_dv_drop", dv_l, 0);

    // 2: back-to-back A5 then 3C
    send_bits(8'hA5, 0, 7);
    chk("t2_dout_a5", dout_l, 8'hA5);
    chk("t2_dv_a5", dv_l, 1);
    chk("t2_sel_wrap", sel_l, 0);
    send_bits(8'h3C, 0, 0);
    chk("t2_dv_gap", dv_l, 0);
    chk("t2_dout_hold", dout_l, 8'hA5);
    chk("t2_sel1", sel_l, 1);
    send_bits(8'h3C, 1, 7);
    chk("t2_dout_3c", dout_l, 8'h3C);
    chk("t2_dv_3c", dv_l, 1);

    // 3: partial word, sof with a beat, then the rest of FF
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    chk("t3_sel3", sel_l, 3);
    drive(1'b1, 1'b1, 1'b1);
    chk("t3_sof_sel", sel_l, 1);
    send_bits(8'hFF, 1, 6);
    chk("t3_no_early", dv_l, 0);
    chk("t3_sel7", sel_l, 7);
    send_bits(8'hFF, 7, 7);
    chk("t3_dout", dout_l, 8'hFF);
    chk("t3_dv", dv_l, 1);
    // sof alone realigns to 0 and discards
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    chk("t3_sof_only_sel", sel_l, 0);

    // 4: consumer stalled, 11 then 22 -> overrun
    dout_ready = 1'b0;
    send_bits(8'h11, 0, 7);
    chk("t4_dout_11", dout_l, 8'h11);
    chk("t4_dout_msb", dout_m, 8'h88);
    chk("t4_dv", dv_l, 1);
    send_bits(8'h22, 0, 6);
    chk("t4_ovr_early", ovr_l, 0);
    send_bits(8'h22, 7, 7);
    chk("t4_ovr", ovr_l, 1);
    chk("t4_ovr_msb", ovr_m, 1);
    chk("t4_dout_kept", dout_l, 8'h11);
    drive(1'b0, 1'b0, 1'b0);
    chk("t4_ovr_pulse", ovr_l, 0);
    chk("t4_dv_held", dv_l, 1);
    dout_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    chk("t4_dv_drop", dv_l, 0);
    chk("t4_dout_retain", dout_l, 8'h11);

    // 5: accept and complete in the same cycle
    dout_ready = 1'b0;
    send_bits(8'h66, 0, 7);
    send_bits(8'h77, 0, 6);
    chk("t5_dout_66", dout_l, 8'h66);
    dout_ready = 1'b1;
    send_bits(8'h77, 7, 7);
    chk("t5_ovr", ovr_l, 0);
    chk("t5_dout_77", dout_l, 8'h77);
    chk("t5_dv", dv_l, 1);

    // 6: reset mid-word with a word held
    dout_ready = 1'b0;
    send_bits(8'h1F, 0, 4);
    chk("t6_sel5", sel_l, 5);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_dv", dv_l, 0);
    chk("t6_rst_sel", sel_l, 0);
    chk("t6_rst_ovr", ovr_l, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dout_ready = 1'b1;
    @(negedge clk);
    send_bits(8'hC3, 0, 7);
    chk("t6_dout", dout_l, 8'hC3);
    chk("t6_dout_msb", dout_m, 8'hC3);
    chk("t6_dv", dv_l, 1);
    send_bits(8'h0B, 0, 7);
    chk("t6_dout_0b", dout_l, 8'h0B);
    chk("t6_dout_0b_msb", dout_m, 8'hD0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
